// File: rtl/regfile_mp_if.sv
// Bus interface for regfile_mp: write-back port, packed read ports and the clear handshake.
// The testbench drives the master modport; the register file uses the slave modport.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic                     reg_write;
    logic [ADDR_W-1:0]        rd_addr;
    logic [DATA_W-1:0]        write_data;
    logic [NUM_RD*ADDR_W-1:0] read_addr;
    logic [NUM_RD*DATA_W-1:0] read_data;
    logic                     clr_req;
    logic                     clr_busy;
    logic                     clr_done;
    logic                     wr_err;

    modport master (
        output reg_write, rd_addr, write_data, read_addr, clr_req,
        input  read_data, clr_busy, clr_done, wr_err
    );

    modport slave (
        input  reg_write, rd_addr, write_data, read_addr, clr_req,
        output read_data, clr_busy, clr_done, wr_err
    );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with $0 hard-wired to zero and a sequential clear engine.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input logic          clk,
    input logic          rst_n,
    regfile_mp_if.slave  io_bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic              r_clr_done;
    logic              r_wr_err;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_clr_busy;
    logic w_clr_last;
    logic w_wr_valid;
    logic w_wr_commit;

    assign w_clr_busy  = (r_state == CLEAR);
    assign w_clr_last  = w_clr_busy && (r_clr_ptr == LAST_ADDR);
    assign w_wr_valid  = io_bus.reg_write && (io_bus.rd_addr != '0);
    assign w_wr_commit = w_wr_valid && !w_clr_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A request arriving on the edge that finishes a clear is dropped, since the FSM is still in CLEAR.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (io_bus.clr_req) begin
                    w_next_state = CLEAR;
                end
            end
            CLEAR: begin
                if (w_clr_last) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_ptr  <= '0;
            r_clr_done <= 1'b0;
            r_wr_err   <= 1'b0;
        end else begin
            r_clr_done <= w_clr_last;
            r_wr_err   <= w_wr_valid && w_clr_busy;
            if (r_state == IDLE && io_bus.clr_req) begin
                r_clr_ptr <= ADDR_W'(1);
            end else if (w_clr_busy) begin
                r_clr_ptr <= r_clr_ptr + ADDR_W'(1);
            end
        end
    end

    // Entry 0 is never written; the read mux forces it to zero regardless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr_commit) begin
                r_mem[io_bus.rd_addr] <= io_bus.write_data;
            end
            if (w_clr_busy) begin
                r_mem[r_clr_ptr] <= '0;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        assign w_ra = io_bus.read_addr[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
        assign io_bus.read_data[k*DATA_W +: DATA_W] =
            (w_ra == '0)                              ? '0 :
            (w_wr_commit && (w_ra == io_bus.rd_addr)) ? io_bus.write_data :
                                                        r_mem[w_ra];
`else
        assign io_bus.read_data[k*DATA_W +: DATA_W] = (w_ra == '0) ? '0 : r_mem[w_ra];
`endif
    end

    assign io_bus.clr_busy = w_clr_busy;
    assign io_bus.clr_done = r_clr_done;
    assign io_bus.wr_err   = r_wr_err;
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the MIPS datapath. It generalises the fixed 32×32, two-read-port register file in width, depth and read-port count, and keeps register 0 hard-wired to zero. It adds a hardware sequential-clear engine with a busy/done handshake, and optional write-to-read forwarding. It sits between instruction decode (read addresses) and write-back (destination and data).

## Interface
- DATA_W, 32, data width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of independent read ports (≥1)
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous, active-low
- reg_write  input  1  write enable
- rd_addr  input  ADDR_W  write destination address
- write_data  input  DATA_W  write data
- read_addr  input  NUM_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- read_data  output  NUM_RD*DATA_W  packed read data; port k uses bits [k*DATA_W +: DATA_W]
- clr_req  input  1  start a sequential clear (sampled at the edge)
- clr_busy  output  1  clear in progress
- clr_done  output  1  one-cycle pulse at the end of a clear
- wr_err  output  1  one-cycle pulse: a write was discarded because a clear was in progress

## Operation
- Reads are combinational on all ports, independent of each other. Address 0 always returns 0.
- A write commits at the rising edge when reg_write=1, rd_addr≠0 and clr_busy=0.
- A write to address 0 is silently ignored. It does not raise wr_err.
- Clear FSM states:
  - IDLE. With clr_req=1 at an edge: clr_ptr←1, go to CLEAR.
  - CLEAR. Each edge: entry[clr_ptr]←0 and clr_ptr increments. The edge that clears entry DEPTH-1 returns the FSM to IDLE and sets clr_done=1 for the following cycle.
- clr_busy=1 exactly while the FSM is in CLEAR.
- clr_req is ignored while in CLEAR. A clr_req on the same edge that ends the clear is also ignored.
- When reg_write=1 with rd_addr≠0 while clr_busy=1, the write is discarded and wr_err=1 for the next cycle.
- During CLEAR, entries below clr_ptr read 0 and the remaining entries read their old values.
- Simultaneous reg_write and clr_req in IDLE: the write commits, and the clear starts on the same edge (it later zeroes that entry).
- Reset values:
  - all entries 0
  - FSM IDLE, clr_ptr 0
  - clr_busy 0, clr_done 0, wr_err 0
  - read_data = 0 on every port

## Timing
- Read latency is 0 cycles (combinational).
- A write is visible on the read ports after the committing edge.
- Clear: clr_req is sampled at edge N.
  - clr_busy is high from edge N until edge N+DEPTH-1. That is DEPTH-1 cycles; 31 at default.
  - clr_done is high for the one cycle after edge N+DEPTH-1.
  - A new clr_req is accepted from edge N+DEPTH onward.
- Reset mid-clear aborts immediately and asynchronously: every entry is 0, the FSM is IDLE and no clr_done is issued.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A read port whose address equals rd_addr while a write would commit (reg_write=1, rd_addr≠0, clr_busy=0) returns write_data in the same cycle.
  - Address 0 still returns 0.
- REGFILE_BYPASS_EN undefined: read ports return the stored value until after the committing edge.

## Test plan
- Assert rst_n=0, then release it. Read every address on every port -> all read 0, and clr_busy, clr_done and wr_err are 0.
- Write $1=abcd_1234, then $2=abcd_5678, then $1=abcd_abcd on successive edges, with port0 on address 1 and port1 on address 2 -> after the third edge, port0=abcd_abcd and port1=abcd_5678.
- Write $0=ffff_ffff -> reading address 0 returns 0, and wr_err stays 0.
- Drive reg_write=1, rd_addr=3, write_data=1234_5678 with port0 on address 3, and observe before the edge -> with REGFILE_BYPASS_EN, 1234_5678; without it, 0. After the edge both builds return 1234_5678.
- Fill $1..$31 with nonzero values, then pulse clr_req -> clr_busy is high for 31 cycles, then clr_done pulses once, and all entries read 0. A write of $5=dead_beef during busy -> wr_err pulses and $5 reads 0 afterwards.
- Start a clear and drop rst_n 10 cycles in -> clr_busy falls immediately, all entries read 0, and no clr_done is issued.
